// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the M-stage load/store path: funct3 codes,
// FSM state encoding, byte-enable patterns and small decode helpers.
package riscv_mem_pkg;

  // RV32I load/store funct3 codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access FSM
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Byte-enable patterns
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Access size from funct3; the unused codes 011/110/111 fall to word.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  // Natural alignment check for a given access size.
  function automatic logic is_aligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 1'b1;
      SZ_H:    return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Load formatter: picks the byte/half lane out of a read word and
// sign- or zero-extends it according to the load funct3.
module load_formatter
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then extension per funct3
  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result_o = {24'd0, byte_sel};
      F3_HU:   result_o = {16'd0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: turns the EX/MEM access into a word-aligned,
// byte-enabled req/ack bus transaction, stalls until the bus answers (or
// times out) and presents the formatted load value for one DONE cycle.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadData,
  output logic        StallMem,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;

  logic        access;
  logic [2:0]  f3_eff;
  size_e       sz;
  logic        aligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] fmt_data;

  // Stores ignore funct3[2]; loads keep it for sign/zero selection.
  assign access  = MemReadM | MemWriteM;
  assign f3_eff  = MemWriteM ? {1'b0, Funct3M[1:0]} : Funct3M;
  assign sz      = f3_size(f3_eff);
  assign aligned = is_aligned(sz, ALUResultM[1:0]);

  // Store lane placement: replicate data so every enabled lane sees it
  always_comb begin
    case (sz)
      SZ_B: begin
        st_be    = BE_BYTE << ALUResultM[1:0];
        st_wdata = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        st_be    = ALUResultM[1] ? BE_HI_HALF : BE_LO_HALF;
        st_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        st_be    = BE_WORD;
        st_wdata = WriteDataM;
      end
    endcase
  end

  load_formatter u_fmt (
    .rdata_i  (dmem_rdata),
    .addr_i   (off_q),
    .funct3_i (f3_q),
    .result_o (fmt_data)
  );

  // Next-state and strobe logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    off_d     = off_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    StallMem  = 1'b0;
    MisalignM = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (aligned) begin
            StallMem = 1'b1;
            state_d  = S_BUSY;
            req_d    = 1'b1;
            we_d     = MemWriteM;
            addr_d   = {ALUResultM[31:2], 2'b00};
            be_d     = MemWriteM ? st_be : BE_WORD;
            wdata_d  = MemWriteM ? st_wdata : 32'd0;
            f3_d     = f3_eff;
            off_d    = ALUResultM[1:0];
            cnt_d    = '0;
            err_d    = 1'b0;
          end else begin
            MisalignM = 1'b1;
          end
        end
      end
      S_BUSY: begin
        StallMem = 1'b1;
        if (dmem_ack) begin
          rdata_d = we_q ? 32'd0 : fmt_data;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bus registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= BE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign ReadData   = (state_q == S_DONE) ? rdata_q : 32'd0;
  assign BusErrM    = (state_q == S_DONE) & err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized accesses
// checked against an arithmetic model of the load/store rules.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadData;
  logic        StallMem, MisalignM, BusErrM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_rd;
  logic [31:0] last_wdata;
  logic [3:0]  last_be;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadData(ReadData), .StallMem(StallMem), .MisalignM(MisalignM),
    .BusErrM(BusErrM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int m_size(input logic [2:0] f3);
    int lo;
    lo = int'(f3[1:0]);
    if (lo == 0) return 1;
    if (lo == 1) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input int size, input int off);
    int v;
    v = ((1 << size) - 1) << off;
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input int size, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [2:0] f3, input int off);
    longint v;
    int size, bits;
    size = m_size(f3);
    bits = 8 * size;
    v = longint'(rd) >> (8 * off);
    v = v & ((64'd1 << bits) - 1);
    if (f3[2] == 1'b0 && size < 4 && ((v >> (bits - 1)) & 1) == 1) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  task automatic set_idle();
    MemReadM = 0; MemWriteM = 0; Funct3M = 0; ALUResultM = 0; WriteDataM = 0;
  endtask

  // One complete access. ack_dly = BUSY cycle index on which ack arrives;
  // ack_dly >= T means the bus never answers.
  task automatic access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_dly,
                        input logic [31:0] rdat);
    int size, off, nbusy;
    bit st, timeout;
    logic [31:0] exp_rd;
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
    dmem_ack = 0;
    #1;
    st = wr;
    size = m_size(f3);
    off = int'(a[1:0]);
    last_rd = 32'hx;
    if ((off % size) != 0) begin
      chk({nm, " misalign"}, {31'd0, MisalignM}, 1);
      chk({nm, " mis stall"}, {31'd0, StallMem}, 0);
      chk({nm, " mis rdata"}, ReadData, 0);
      @(posedge clk); @(negedge clk);
      chk({nm, " mis noreq"}, {31'd0, dmem_req}, 0);
      chk({nm, " mis stall2"}, {31'd0, StallMem}, 0);
      set_idle();
      return;
    end
    chk({nm, " idle stall"}, {31'd0, StallMem}, 1);
    chk({nm, " idle misal"}, {31'd0, MisalignM}, 0);
    timeout = (ack_dly >= T);
    nbusy = timeout ? T : ack_dly + 1;
    for (int k = 0; k < nbusy; k++) begin
      @(posedge clk); @(negedge clk);
      dmem_ack = 0;
      chk({nm, " busy stall"}, {31'd0, StallMem}, 1);
      chk({nm, " busy req"}, {31'd0, dmem_req}, 1);
      chk({nm, " busy we"}, {31'd0, dmem_we}, {31'd0, st});
      chk({nm, " addr"}, dmem_addr, {a[31:2], 2'b00});
      chk({nm, " be"}, {28'd0, dmem_be}, {28'd0, st ? m_be(size, off) : 4'hF});
      if (st) chk({nm, " wdata"}, dmem_wdata, m_wdata(size, wd));
      last_be = dmem_be;
      last_wdata = dmem_wdata;
      // inputs change while BUSY must have no effect
      MemReadM = 1'($urandom); MemWriteM = 1'($urandom); Funct3M = 3'($urandom);
      ALUResultM = $urandom; WriteDataM = $urandom;
      if (k == ack_dly) begin
        dmem_ack = 1; dmem_rdata = rdat;
      end else begin
        dmem_rdata = $urandom;
      end
    end
    @(posedge clk); @(negedge clk);
    dmem_ack = 0;
    exp_rd = (st || timeout) ? 32'd0 : m_load(rdat, f3, off);
    last_rd = ReadData;
    chk({nm, " done stall"}, {31'd0, StallMem}, 0);
    chk({nm, " done rdata"}, ReadData, exp_rd);
    chk({nm, " done buserr"}, {31'd0, BusErrM}, {31'd0, timeout});
    chk({nm, " done req"}, {31'd0, dmem_req}, 0);
    chk({nm, " done we"}, {31'd0, dmem_we}, 0);
    set_idle();
  endtask

  initial begin
    rst = 1; set_idle(); dmem_ack = 1; dmem_rdata = 32'hA5A5_A5A5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0; #1;
    chk("rst req", {31'd0, dmem_req}, 0);
    chk("rst we", {31'd0, dmem_we}, 0);
    chk("rst addr", dmem_addr, 0);
    chk("rst wdata", dmem_wdata, 0);
    chk("rst be", {28'd0, dmem_be}, 0);
    chk("rst rdata", ReadData, 0);
    chk("rst stall", {31'd0, StallMem}, 0);
    chk("rst buserr", {31'd0, BusErrM}, 0);
    // stale ack in IDLE must not start anything
    @(posedge clk); @(negedge clk);
    chk("stale req", {31'd0, dmem_req}, 0);
    chk("stale stall", {31'd0, StallMem}, 0);
    dmem_ack = 0;

    // directed cases
    access("LW", 1, 0, 3'b010, 32'h0000_1008, 0, 0, 32'hDEAD_BEEF);
    chk("LW const", last_rd, 32'hDEAD_BEEF);
    access("LB", 1, 0, 3'b000, 32'h0000_1003, 0, 1, 32'h80FF_0000);
    chk("LB const", last_rd, 32'hFFFF_FF80);
    access("LBU", 1, 0, 3'b100, 32'h0000_1003, 0, 0, 32'h80FF_0000);
    chk("LBU const", last_rd, 32'h0000_0080);
    access("LHU", 1, 0, 3'b101, 32'h0000_1002, 0, 2, 32'h80FF_0000);
    chk("LHU const", last_rd, 32'h0000_80FF);
    access("SH", 0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 0);
    chk("SH be const", {28'd0, last_be}, 32'hC);
    chk("SH wd const", last_wdata, 32'hABCD_ABCD);
    access("SB", 0, 1, 3'b000, 32'h0000_2001, 32'h1234_ABCD, 0, 0);
    chk("SB be const", {28'd0, last_be}, 32'h2);
    chk("SB wd const", last_wdata, 32'hCDCD_CDCD);
    access("LWmis", 1, 0, 3'b010, 32'h0000_1002, 0, 0, 0);
    access("SBU", 0, 1, 3'b100, 32'h0000_3003, 32'h0000_0077, 0, 0);
    access("TMO", 1, 0, 3'b010, 32'h0000_4000, 0, T, 32'h1111_1111);
    access("ACKLAST", 1, 0, 3'b001, 32'h0000_4002, 0, T - 1, 32'h8001_0000);

    // reset in 2nd BUSY cycle, ack one cycle later
    @(negedge clk);
    MemReadM = 1; Funct3M = 3'b010; ALUResultM = 32'h0000_1008;
    @(posedge clk); @(negedge clk);
    chk("rb busy1 req", {31'd0, dmem_req}, 1);
    @(posedge clk); @(negedge clk);
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0; set_idle(); dmem_ack = 1; dmem_rdata = 32'h1234_5678;
    #1;
    chk("rb req", {31'd0, dmem_req}, 0);
    chk("rb stall", {31'd0, StallMem}, 0);
    chk("rb rdata", ReadData, 0);
    @(posedge clk); @(negedge clk);
    dmem_ack = 0;
    chk("rb stall2", {31'd0, StallMem}, 0);
    chk("rb buserr", {31'd0, BusErrM}, 0);
    chk("rb rdata2", ReadData, 0);
    chk("rb req2", {31'd0, dmem_req}, 0);

    // randomized accesses
    for (int n = 0; n < 150; n++) begin
      logic rd, wr;
      logic [31:0] a;
      int pick;
      pick = $urandom_range(0, 3);
      rd = (pick != 1);
      wr = (pick == 1 || pick == 2);
      a = $urandom;
      access("RND", rd, wr, 3'($urandom), a, $urandom, $urandom_range(0, T + 1), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
